// File: rtl/button_event_scheduler.sv
// Debounces NUM_PB push buttons on a shared tick and queues PRESS/RELEASE/LONG
// events through one pending slot per button into a round-robin output register.
module button_event_scheduler #(
  parameter int unsigned NUM_PB       = 4,
  parameter int unsigned TICK_DIV     = 24000,
  parameter int unsigned STABLE_TICKS = 11,
  parameter int unsigned LONG_TICKS   = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_PB-1:0] pb,
  output logic [NUM_PB-1:0] clean_pb,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [2:0]        ev_id,
  output logic [1:0]        ev_code,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = $clog2(STABLE_TICKS + 1);
  localparam int unsigned LW = $clog2(LONG_TICKS + 1);

  typedef enum logic [1:0] {
    EV_NONE    = 2'b00,
    EV_PRESS   = 2'b01,
    EV_RELEASE = 2'b10,
    EV_LONG    = 2'b11
  } ev_code_e;

  logic [NUM_PB-1:0] sync1_q, sync2_q;
  logic [NUM_PB-1:0] clean_q, clean_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [SW-1:0]     stab_q [NUM_PB];
  logic [SW-1:0]     stab_d [NUM_PB];
  logic [LW-1:0]     long_q [NUM_PB];
  logic [LW-1:0]     long_d [NUM_PB];
  logic [NUM_PB-1:0] toggle;
  logic [NUM_PB-1:0] new_ev;
  ev_code_e          new_code [NUM_PB];

  logic [NUM_PB-1:0] occ_q, occ_d;
  ev_code_e          slot_q [NUM_PB];
  ev_code_e          slot_d [NUM_PB];
  logic [2:0]        last_q, last_d;
  logic              gnt_vld;
  logic [2:0]        gnt_id;
  logic [NUM_PB-1:0] gnt_oh;
  ev_code_e          gnt_code;
  logic              take;
  logic              drop;

  logic              out_vld_q, out_vld_d;
  logic [2:0]        out_id_q, out_id_d;
  ev_code_e          out_code_q, out_code_d;
  logic              ovf_q, ovf_d;

  always_comb begin
    tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    clean_d    = clean_q;
    toggle     = '0;
    new_ev     = '0;
    for (int unsigned i = 0; i < NUM_PB; i++) begin
      stab_d[i]   = stab_q[i];
      long_d[i]   = long_q[i];
      new_code[i] = EV_NONE;
      if (tick) begin
        if (sync2_q[i] == clean_q[i]) begin
          stab_d[i] = '0;
        end else if (stab_q[i] == SW'(STABLE_TICKS - 1)) begin
          stab_d[i]   = '0;
          toggle[i]   = 1'b1;
          clean_d[i]  = ~clean_q[i];
          new_ev[i]   = 1'b1;
          new_code[i] = clean_q[i] ? EV_RELEASE : EV_PRESS;
        end else begin
          stab_d[i] = stab_q[i] + SW'(1);
        end
      end
      // A release decided on the same tick suppresses a coincident LONG.
      if (!clean_q[i]) begin
        long_d[i] = '0;
      end else if (tick && !toggle[i] && long_q[i] != LW'(LONG_TICKS)) begin
        long_d[i] = long_q[i] + LW'(1);
        if (long_q[i] == LW'(LONG_TICKS - 1)) begin
          new_ev[i]   = 1'b1;
          new_code[i] = EV_LONG;
        end
      end
    end
  end

  // Round-robin search starting one past the last granted slot.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_id   = '0;
    gnt_oh   = '0;
    gnt_code = EV_NONE;
    for (int unsigned k = 1; k <= NUM_PB; k++) begin
      for (int unsigned j = 0; j < NUM_PB; j++) begin
        if (!gnt_vld && occ_q[j] && j == (32'(last_q) + k) % NUM_PB) begin
          gnt_vld   = 1'b1;
          gnt_id    = 3'(j);
          gnt_oh[j] = 1'b1;
          gnt_code  = slot_q[j];
        end
      end
    end
    take = gnt_vld && (!out_vld_q || ev_ready);
  end

  always_comb begin
    occ_d      = occ_q;
    drop       = 1'b0;
    last_d     = take ? gnt_id : last_q;
    out_vld_d  = out_vld_q;
    out_id_d   = out_id_q;
    out_code_d = out_code_q;
    for (int unsigned j = 0; j < NUM_PB; j++) begin
      slot_d[j] = slot_q[j];
      if (take && gnt_oh[j]) occ_d[j] = 1'b0;
      if (new_ev[j]) begin
        if (occ_q[j] && !(take && gnt_oh[j])) begin
          drop = 1'b1;
        end else begin
          occ_d[j]  = 1'b1;
          slot_d[j] = new_code[j];
        end
      end
    end
    if (take) begin
      out_vld_d  = 1'b1;
      out_id_d   = gnt_id;
      out_code_d = gnt_code;
    end else if (out_vld_q && ev_ready) begin
      out_vld_d = 1'b0;
    end
    if (clr_overflow)  ovf_d = 1'b0;
    else if (drop)     ovf_d = 1'b1;
    else               ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      clean_q    <= '0;
      tick_cnt_q <= '0;
      occ_q      <= '0;
      last_q     <= 3'(NUM_PB - 1);
      out_vld_q  <= 1'b0;
      out_id_q   <= '0;
      out_code_q <= EV_NONE;
      ovf_q      <= 1'b0;
      for (int unsigned i = 0; i < NUM_PB; i++) begin
        stab_q[i] <= '0;
        long_q[i] <= '0;
        slot_q[i] <= EV_NONE;
      end
    end else begin
      sync1_q    <= pb;
      sync2_q    <= sync1_q;
      clean_q    <= clean_d;
      tick_cnt_q <= tick_cnt_d;
      occ_q      <= occ_d;
      last_q     <= last_d;
      out_vld_q  <= out_vld_d;
      out_id_q   <= out_id_d;
      out_code_q <= out_code_d;
      ovf_q      <= ovf_d;
      for (int unsigned i = 0; i < NUM_PB; i++) begin
        stab_q[i] <= stab_d[i];
        long_q[i] <= long_d[i];
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign clean_pb = clean_q;
  assign ev_valid = out_vld_q;
  assign ev_id    = out_id_q;
  assign ev_code  = out_code_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler with TICK_DIV=4, STABLE_TICKS=3,
// LONG_TICKS=10; cycle numbers count edges after reset release.
module tb_button_event_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pb;
  logic [3:0] clean_pb;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] ev_id;
  logic [1:0] ev_code;
  logic       overflow;
  logic       clr_overflow;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit seen_valid;

  always #5 clk = ~clk;

  button_event_scheduler #(
    .NUM_PB       (4),
    .TICK_DIV     (4),
    .STABLE_TICKS (3),
    .LONG_TICKS   (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pb           (pb),
    .clean_pb     (clean_pb),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_id        (ev_id),
    .ev_code      (ev_code),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [2:0] id,
                         input logic [1:0] code);
    chk({tag, ".valid"}, 32'(ev_valid), 32'(v));
    chk({tag, ".id"},    32'(ev_id),    32'(id));
    chk({tag, ".code"},  32'(ev_code),  32'(code));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".valid"}, 32'(ev_valid), 0);
    chk({tag, ".id"},    32'(ev_id),    0);
    chk({tag, ".code"},  32'(ev_code),  0);
    chk({tag, ".clean"}, 32'(clean_pb), 0);
    chk({tag, ".ovf"},   32'(overflow), 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (ev_valid) seen_valid = 1'b1;
  endtask

  task automatic step_to(input int k);
    while (cyc < k) step();
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    pb           = '0;
    clr_overflow = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    ev_ready = 1'b1;

    // Single press with long hold
    do_reset();
    chk_reset_vals("A.rst");
    step_to(1);  pb = 4'b0010;
    step_to(11); chk("A.clean_pre", 32'(clean_pb), 0);
    step_to(12); chk("A.clean", 32'(clean_pb), 4'b0010);
                 chk("A.lat0", 32'(ev_valid), 0);
    step_to(13); chk_out("A.press", 1'b1, 3'd1, 2'b01);
    step_to(14); chk("A.drop_valid", 32'(ev_valid), 0);
    step_to(52); chk("A.long_pre", 32'(ev_valid), 0);
    step_to(53); chk_out("A.long", 1'b1, 3'd1, 2'b11);
    step_to(54); chk("A.long_done", 32'(ev_valid), 0);

    // Short glitch between tick boundaries
    do_reset();
    seen_valid = 1'b0;
    step_to(2);  pb = 4'b0001;
    step_to(5);  pb = 4'b0000;
    step_to(40); chk("B.clean", 32'(clean_pb), 0);
                 chk("B.no_event", 32'(seen_valid), 0);

    // All buttons together, release, re-press
    do_reset();
    step_to(1);  pb = 4'b1111;
    step_to(12); chk("C.clean", 32'(clean_pb), 4'hF);
                 chk("C.lat0", 32'(ev_valid), 0);
    for (int i = 0; i < 4; i++) begin
      step_to(13 + i); chk_out("C.press", 1'b1, 3'(i), 2'b01);
    end
    step_to(17); chk("C.idle", 32'(ev_valid), 0);
    pb = 4'b0000;
    step_to(28); chk("C.clean_rel", 32'(clean_pb), 0);
    for (int i = 0; i < 4; i++) begin
      step_to(29 + i); chk_out("C.release", 1'b1, 3'(i), 2'b10);
    end
    pb = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step_to(45 + i); chk_out("C.repress", 1'b1, 3'(i), 2'b01);
    end
    step_to(49); chk("C.idle2", 32'(ev_valid), 0);

    // Round-robin from a mid grant, with output held
    do_reset();
    ev_ready = 1'b0;
    step_to(1);  pb = 4'b0010;
    step_to(13); chk_out("R.first", 1'b1, 3'd1, 2'b01);
    pb = 4'b1011;
    step_to(24); chk_out("R.hold", 1'b1, 3'd1, 2'b01);
                 chk("R.clean", 32'(clean_pb), 4'b1011);
    ev_ready = 1'b1;
    step_to(25); chk_out("R.next3", 1'b1, 3'd3, 2'b01);
    step_to(26); chk_out("R.next0", 1'b1, 3'd0, 2'b01);
    step_to(27); chk("R.idle", 32'(ev_valid), 0);

    // Pending slot overflow and clear
    do_reset();
    ev_ready = 1'b0;
    step_to(1);  pb = 4'b0100;
    step_to(13); chk_out("D.press", 1'b1, 3'd2, 2'b01);
    pb = 4'b0000;
    step_to(24); chk("D.clean_rel", 32'(clean_pb), 0);
                 chk("D.ovf0", 32'(overflow), 0);
                 chk_out("D.held", 1'b1, 3'd2, 2'b01);
    pb = 4'b0100;
    step_to(35); chk("D.ovf_pre", 32'(overflow), 0);
    step_to(36); chk("D.ovf_set", 32'(overflow), 1);
                 chk("D.clean_re", 32'(clean_pb), 4'b0100);
                 chk_out("D.held2", 1'b1, 3'd2, 2'b01);
    clr_overflow = 1'b1;
    step_to(37); chk("D.ovf_clr", 32'(overflow), 0);
    clr_overflow = 1'b0;
    ev_ready = 1'b1;
    step_to(38); chk_out("D.release", 1'b1, 3'd2, 2'b10);
    step_to(39); chk("D.dropped", 32'(ev_valid), 0);
                 chk("D.ovf_stay", 32'(overflow), 0);

    // Reset while an event is on the output and the button is held
    do_reset();
    ev_ready = 1'b0;
    step_to(1);  pb = 4'b1000;
    step_to(13); chk_out("E.press", 1'b1, 3'd3, 2'b01);
    rst_n = 1'b0;
    step();
    chk_reset_vals("E.rst");
    rst_n    = 1'b1;
    ev_ready = 1'b1;
    cyc      = 0;
    step_to(11); chk("E.clean_pre", 32'(clean_pb), 0);
                 chk("E.valid_pre", 32'(ev_valid), 0);
    step_to(12); chk("E.clean", 32'(clean_pb), 4'b1000);
    step_to(13); chk_out("E.repress", 1'b1, 3'd3, 2'b01);
    step_to(14); chk("E.idle", 32'(ev_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/button_event_scheduler.md
BUTTON_EVENT_SCHEDULER -- requirements
Module: button_event_scheduler

Interface
REQ-001 SHALL have parameter NUM_PB, default 4: number of push-button inputs (2..8).
REQ-002 SHALL have parameter TICK_DIV, default 24000: clk cycles per debounce tick (1 ms at 24 MHz).
REQ-003 SHALL have parameter STABLE_TICKS, default 11: consecutive ticks of a differing level required to change clean state.
REQ-004 SHALL have parameter LONG_TICKS, default 1000: ticks a button stays pressed before the long-press event.
REQ-005 SHALL have port clk  input  1  the single clock; all logic rises on posedge clk.
REQ-006 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have port pb  input  NUM_PB  raw asynchronous button levels, 1 = pressed.
REQ-008 SHALL have port clean_pb  output  NUM_PB  debounced button levels.
REQ-009 SHALL have port ev_valid  output  1  event word available.
REQ-010 SHALL have port ev_ready  input  1  consumer accepts the event.
REQ-011 SHALL have port ev_id  output  3  button index of the event.
REQ-012 SHALL have port ev_code  output  2  event type: 01 PRESS, 10 RELEASE, 11 LONG; 00 never issued.
REQ-013 SHALL have port overflow  output  1  sticky flag: an event was dropped.
REQ-014 SHALL have port clr_overflow  input  1  clears overflow.

Function
REQ-015 SHALL pass each pb bit through a 2-flop synchroniser before any use.
REQ-016 SHALL use one shared tick counter, 0..TICK_DIV-1, that wraps to 0 and asserts an internal tick for one cycle at TICK_DIV-1.
REQ-017 SHALL, per button on each tick: clear the stable count if the synchronised level equals clean_pb, else increment it.
REQ-018 SHALL toggle clean_pb[i] and clear its stable count on the tick where the count reaches STABLE_TICKS-1 with the level still differing; any glitch shorter than one tick boundary is ignored.
REQ-019 SHALL generate PRESS on a 0->1 change and RELEASE on a 1->0 change of clean_pb[i], in the same cycle clean_pb changes.
REQ-020 SHALL count ticks while clean_pb[i]=1, emit LONG once when the count reaches LONG_TICKS, then saturate; the count clears when clean_pb[i]=0.
REQ-021 SHALL hold one pending slot per button (empty/occupied plus code); a new event loads the slot in its generation cycle.
REQ-022 SHALL, when a new event finds its slot occupied and not being drained that cycle, drop the new event, keep the old one, and set overflow.
REQ-023 SHALL, when a slot is drained and refilled in the same cycle, output the old event and keep the new one pending without overflow.
REQ-024 SHALL grant among occupied slots round-robin, searching from last_grant+1 modulo NUM_PB.
REQ-025 SHALL load the output register (ev_id, ev_code, ev_valid=1) and clear the granted slot when ev_valid=0, or when ev_valid=1 and ev_ready=1 (back-to-back, one event per cycle).
REQ-026 SHALL hold ev_id/ev_code stable while ev_valid=1 and ev_ready=0.
REQ-027 SHALL drop ev_valid the cycle after acceptance when no slot is occupied.
REQ-028 SHALL give ev_valid latency of exactly 1 cycle from the clean_pb change when the output register is free.
REQ-029 SHALL, on the same cycle, give clr_overflow priority over a new overflow set.

Reset
REQ-030 SHALL, on a clk edge with rst_n=0, set clean_pb=0, ev_valid=0, ev_id=0, ev_code=00, overflow=0, sync flops, tick, stable and long counters=0, all slots empty, last_grant=NUM_PB-1.
REQ-031 SHALL, with a button held through reset, report PRESS after STABLE_TICKS ticks following rst_n=1; an event in flight at reset is lost without an overflow indication.

Verification (TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=10, NUM_PB=4)
REQ-032 SHALL cover: pb[1] rises and holds, ev_ready=1 -> clean_pb[1]=1 on the 3rd tick after sync, ev_valid one cycle later with id=1, code=01; LONG (11) 10 ticks after that.
REQ-033 SHALL cover: pb[0] pulses high for 3 clk with no tick boundary held high -> clean_pb stays 0, no event.
REQ-034 SHALL cover: pb[0..3] rise in the same cycle, ev_ready=1 -> ids 0,1,2,3 on consecutive cycles, each code 01; then a second round after re-presses starts at id 0 following last_grant=3.
REQ-035 SHALL cover: ev_ready=0, pb[2] press then release -> PRESS held on output, RELEASE pending; a further press drops, overflow=1; clr_overflow -> overflow=0.
REQ-036 SHALL cover: rst_n=0 for 1 cycle while ev_valid=1 and pb[3] held -> outputs return to reset values next edge; PRESS for id 3 reissued 3 ticks after rst_n=1.
